hrfp_mult_normalize_pipe: RTL and testbench

Parametrised, pipelined post-multiply normalizer for the HRFP (hexadecimal-radix floating point) multiplier datapath. It takes the raw product mantissa, exponent and sign and counts leading zero hex digits, up to a configurable limit. It then shifts the mantissa left by whole digits and decrements the exponent to match. Zero and exponent-underflow results are flagged. It replaces the fixed single-digit normalizer with a valid/ready pipeline that supports back-pressure, so it can sit between the multiplier array and the rounding stage.

---
 rtl/hrfp_mult_normalize_pipe.sv | 126 ++++++++++++
 tb/tb_hrfp_mult_normalize_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hrfp_mult_normalize_pipe.sv
// HRFP post-multiply normalizer: two-stage valid/ready pipe that strips
// up to MAX_SHIFT leading zero digits and flags zero / exponent underflow.
module hrfp_mult_normalize_pipe #(
  parameter int MANT_W    = 54,
  parameter int DIGIT_W   = 4,
  parameter int EXP_W     = 7,
  parameter int MAX_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mantissa,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mantissa,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_underflow
);

  localparam int LZW = $clog2(MAX_SHIFT + 1);

  logic              s1_v;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic              s1_sign;
  logic              s1_zero;
  logic [LZW-1:0]    s1_lzd;
  logic              s2_v;

  logic              s2_load;
  logic              s1_fire;
  logic              s1_load;
  logic              in_fire;

  assign out_valid = s2_v;
  assign s2_load   = !s2_v || out_ready;
  assign s1_fire   = s1_v && s2_load;
  assign s1_load   = !s1_v || s1_fire;
  assign in_ready  = !rst && s1_load;
  assign in_fire   = in_valid && in_ready;

  // leading zero digit count, saturating at MAX_SHIFT
  logic [LZW-1:0] lzd_c;
  logic           run;

  always_comb begin
    lzd_c = '0;
    run   = 1'b1;
    for (int i = 0; i < MAX_SHIFT; i++) begin
      if (run && in_mantissa[MANT_W-1-i*DIGIT_W -: DIGIT_W] == '0)
        lzd_c = LZW'(i + 1);
      else
        run = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_mant <= '0;
      s1_exp  <= '0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_lzd  <= '0;
    end else begin
      if (s1_load)
        s1_v <= in_valid;
      if (in_fire) begin
        s1_mant <= in_mantissa;
        s1_exp  <= in_exp;
        s1_sign <= in_sign;
        s1_zero <= (in_mantissa == '0);
        s1_lzd  <= lzd_c;
      end
    end
  end

  logic [MANT_W-1:0] mant_sh;
  logic [EXP_W:0]    exp_diff;
  logic              uflow;

  always_comb begin
    mant_sh = s1_mant;
    for (int i = 1; i <= MAX_SHIFT; i++) begin
      if (s1_lzd == LZW'(i))
        mant_sh = s1_mant << (i * DIGIT_W);
    end
    exp_diff = {1'b0, s1_exp} - (EXP_W + 1)'(s1_lzd);
    uflow    = !s1_zero && exp_diff[EXP_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v          <= 1'b0;
      out_mantissa  <= '0;
      out_exp       <= '0;
      out_sign      <= 1'b0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (s2_load)
        s2_v <= s1_v;
      if (s1_fire) begin
        out_sign <= s1_sign;
        // zero and underflow both flush to a signed zero
        if (s1_zero || uflow) begin
          out_mantissa  <= '0;
          out_exp       <= '0;
          out_zero      <= 1'b1;
          out_underflow <= uflow;
        end else begin
          out_mantissa  <= mant_sh;
          out_exp       <= exp_diff[EXP_W-1:0];
          out_zero      <= 1'b0;
          out_underflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hrfp_mult_normalize_pipe.sv
// Directed bench for hrfp_mult_normalize_pipe: vector table plus
// back-pressure and mid-stream reset sequences.
module tb_hrfp_mult_normalize_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] in_mantissa;
  logic [6:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [53:0] out_mantissa;
  logic [6:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_underflow;

  hrfp_mult_normalize_pipe #(
    .MANT_W(54), .DIGIT_W(4), .EXP_W(7), .MAX_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mantissa(in_mantissa),
    .in_exp(in_exp),
    .in_sign(in_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mantissa(out_mantissa),
    .out_exp(out_exp),
    .out_sign(out_sign),
    .out_zero(out_zero),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [53:0] m;
    logic [6:0]  e;
    logic        s;
    logic [53:0] om;
    logic [6:0]  oe;
    logic        oz;
    logic        ou;
  } vec_t;

  vec_t vt[9];

  int n_vec = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  logic [60:0] rx_q[$];

  int          base;
  int          rx_base;
  int          budget;
  logic [53:0] hold_m;
  logic [6:0]  hold_e;
  logic        have;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (in_valid && in_ready)
      acc_cnt++;
    if (out_valid && out_ready)
      rx_q.push_back({out_mantissa, out_exp});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_mantissa = '0;
    in_exp = '0;
    in_sign = 1'b0;
    out_ready = 1'b1;

    vt[0] = '{m:54'h9 << 50, e:7'h41, s:1'b1,
              om:54'h9 << 50, oe:7'h41, oz:1'b0, ou:1'b0};
    vt[1] = '{m:54'h3 << 46, e:7'h41, s:1'b0,
              om:54'h3 << 50, oe:7'h40, oz:1'b0, ou:1'b0};
    vt[2] = '{m:54'h1 << 38, e:7'h10, s:1'b0,
              om:54'h1 << 46, oe:7'h0E, oz:1'b0, ou:1'b0};
    vt[3] = '{m:54'h1 << 38, e:7'h01, s:1'b0,
              om:54'h0, oe:7'h00, oz:1'b1, ou:1'b1};
    vt[4] = '{m:54'h0, e:7'h55, s:1'b1,
              om:54'h0, oe:7'h00, oz:1'b1, ou:1'b0};
    vt[5] = '{m:54'h1 << 42, e:7'h02, s:1'b1,
              om:54'h1 << 50, oe:7'h00, oz:1'b0, ou:1'b0};
    vt[6] = '{m:54'h3, e:7'h20, s:1'b0,
              om:54'h300, oe:7'h1E, oz:1'b0, ou:1'b0};
    vt[7] = '{m:{54{1'b1}}, e:7'h00, s:1'b0,
              om:{54{1'b1}}, oe:7'h00, oz:1'b0, ou:1'b0};
    vt[8] = '{m:54'h3 << 46, e:7'h00, s:1'b1,
              om:54'h0, oe:7'h00, oz:1'b1, ou:1'b1};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mant", 64'(out_mantissa), 64'd0);
    chk("rst_flags", 64'({out_exp, out_sign, out_zero, out_underflow}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mantissa = vt[i].m;
      in_exp = vt[i].e;
      in_sign = vt[i].s;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk($sformatf("v%0d_early", i), 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_mant", i), 64'(out_mantissa), 64'(vt[i].om));
      chk($sformatf("v%0d_exp", i), 64'(out_exp), 64'(vt[i].oe));
      chk($sformatf("v%0d_sign", i), 64'(out_sign), 64'(vt[i].s));
      chk($sformatf("v%0d_zero", i), 64'(out_zero), 64'(vt[i].oz));
      chk($sformatf("v%0d_uflow", i), 64'(out_underflow), 64'(vt[i].ou));
    end

    // back-pressure: 5 beats, out_ready low for the first 6 cycles
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    base = acc_cnt;
    rx_base = rx_q.size();
    have = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          in_valid = 1'b1;
          in_mantissa = 54'(k + 1) << 50;
          in_exp = 7'(16 + k);
          in_sign = k[0];
          budget = 0;
          do begin
            @(posedge clk);
            #1;
            budget++;
          end while (acc_cnt - base <= k && budget < 40);
          if (acc_cnt - base <= k)
            chk($sformatf("bp_accept_timeout%0d", k), 64'(acc_cnt - base),
                64'(k + 1));
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (!have) begin
              hold_m = out_mantissa;
              hold_e = out_exp;
              have = 1'b1;
            end else begin
              chk("bp_hold_mant", 64'(out_mantissa), 64'(hold_m));
              chk("bp_hold_exp", 64'(out_exp), 64'(hold_e));
            end
          end
        end
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(acc_cnt - base), 64'd2);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join

    budget = 0;
    while (rx_q.size() - rx_base < 5 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    chk("bp_drain_count", 64'(rx_q.size() - rx_base), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (rx_base + k < rx_q.size())
        chk($sformatf("bp_order%0d", k), 64'(rx_q[rx_base + k]),
            64'({54'(k + 1) << 50, 7'(16 + k)}));
    end
    repeat (3) @(negedge clk);
    chk("bp_no_dup", 64'(rx_q.size() - rx_base), 64'd5);

    // reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mantissa = 54'h7 << 50;
    in_exp = 7'h20;
    @(posedge clk);
    #1 in_mantissa = 54'h5 << 50;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rs_out_valid_pre", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_in_ready_hold", 64'(in_ready), 64'd0);
    chk("rs_mant_clr", 64'(out_mantissa), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    rx_base = rx_q.size();
    repeat (5) begin
      @(negedge clk);
      chk("rs_no_stale", 64'(out_valid), 64'd0);
    end
    chk("rs_rx_empty", 64'(rx_q.size() - rx_base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
